// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the sequential multi-precision adder.
//   WORD_W_DEF / NWORDS_DEF : default word width and word count
//   state_t                 : FSM state encoding (ST_IDLE, ST_RUN, ST_DRAIN)
//   cnt_width()             : width of a counter that must reach n inclusive
package multiword_add_seq_pkg;

  localparam int WORD_W_DEF = 16;
  localparam int NWORDS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // The word counter steps one past the last index before DRAIN clears it.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/multiword_add_seq_add_word_core.sv
// add_word_core: combinational WORD_W-bit adder stage with carry in/out.
//   a, b      : operand words
//   ci        : carry into bit 0
//   s         : sum word (modulo 2^WORD_W)
//   co        : carry out of the MSB
//   c_msb_in  : carry into the MSB (only when OVERFLOW_FLAG_EN is defined)
// Optional feature macro: OVERFLOW_FLAG_EN
module add_word_core
  import multiword_add_seq_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              ci,
  output logic [WORD_W-1:0] s,
  output logic              co
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic              c_msb_in
`endif
);

  logic [WORD_W:0] sum_ext;

  assign sum_ext = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, ci};
  assign s       = sum_ext[WORD_W-1:0];
  assign co      = sum_ext[WORD_W];

`ifdef OVERFLOW_FLAG_EN
  // The MSB sum bit is a^b^carry_in, so the carry into it falls out by XOR.
  assign c_msb_in = a[WORD_W-1] ^ b[WORD_W-1] ^ s[WORD_W-1];
`endif

endmodule

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: sequential multi-precision adder. Two NWORDS x WORD_W
// operands arrive LSW-first, one word pair per accepted beat; the carry is
// registered between beats and each sum word leaves through a one-deep
// output register.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, cin           : begin a new addition in IDLE, initial carry
//   in_valid/in_ready    : operand word handshake (a_word, b_word)
//   out_valid/out_ready  : sum word handshake (s_word, s_last)
//   cout                 : final carry, valid with out_valid && s_last
//   busy                 : FSM not in IDLE
//   ovf                  : signed overflow of the full operand (only when
//                          OVERFLOW_FLAG_EN is defined)
// Optional feature macro: OVERFLOW_FLAG_EN
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int NWORDS = NWORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cin,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a_word,
  input  logic [WORD_W-1:0] b_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] s_word,
  output logic              s_last,
  output logic              cout,
  output logic              busy
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic              ovf
`endif
);

  localparam int CNT_W = cnt_width(NWORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

  state_t            state_q;
  logic              carry_q;
  logic [CNT_W-1:0]  word_cnt_q;

  logic [WORD_W-1:0] sum_p0;
  logic              co_p0;
  logic              accept_p0;
  logic              last_p0;

  logic [WORD_W-1:0] s_word_p1;
  logic              s_last_p1;
  logic              vld_p1;
  logic              cout_p1;

`ifdef OVERFLOW_FLAG_EN
  logic              c_msb_p0;
  logic              ovf_p1;
`endif

  // ---- stage p0: combinational word add on the accepted pair ----
  add_word_core #(
    .WORD_W (WORD_W)
  ) u_core (
    .a        (a_word),
    .b        (b_word),
    .ci       (carry_q),
    .s        (sum_p0),
    .co       (co_p0)
`ifdef OVERFLOW_FLAG_EN
    ,
    .c_msb_in (c_msb_p0)
`endif
  );

  // A new pair may enter whenever the output register is empty or is being
  // emptied this same cycle, so back-pressure costs no bubble.
  assign in_ready  = (state_q == ST_RUN) && (!vld_p1 || out_ready);
  assign accept_p0 = in_valid && in_ready;
  assign last_p0   = (word_cnt_q == LAST_CNT);

  // ---- stage p1: FSM, carry/counter and output registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      carry_q    <= 1'b0;
      word_cnt_q <= '0;
      s_word_p1  <= '0;
      s_last_p1  <= 1'b0;
      vld_p1     <= 1'b0;
      cout_p1    <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_p1     <= 1'b0;
`endif
    end else begin
      // Output register: load on accept, otherwise drain on out_ready. Data
      // fields only change on accept, so they hold while stalled.
      if (accept_p0) begin
        s_word_p1 <= sum_p0;
        s_last_p1 <= last_p0;
        vld_p1    <= 1'b1;
      end else if (out_ready) begin
        vld_p1    <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_RUN;
            carry_q    <= cin;
            word_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          if (accept_p0) begin
            carry_q    <= co_p0;
            word_cnt_q <= word_cnt_q + CNT_W'(1);
            if (last_p0) begin
              cout_p1 <= co_p0;
`ifdef OVERFLOW_FLAG_EN
              ovf_p1  <= co_p0 ^ c_msb_p0;
`endif
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (vld_p1 && out_ready) begin
            state_q    <= ST_IDLE;
            carry_q    <= 1'b0;
            word_cnt_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = vld_p1;
  assign s_word    = s_word_p1;
  assign s_last    = s_last_p1;
  assign cout      = cout_p1;
  assign busy      = (state_q != ST_IDLE);
`ifdef OVERFLOW_FLAG_EN
  assign ovf       = ovf_p1;
`endif

endmodule
